imem_loader: RTL

- Byte-stream loader/reader that owns port B of the instruction memory.
- Lets a host (UART bridge or debug link) write program images into imem and read them back.
- Holds the core off (core_hold) for the whole transaction.
- Sits between the host byte link and imem port B; port A stays with the core.

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states, command codes and response codes for the imem loader
package imem_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    WDATA,
    WWRITE,
    RREQ,
    RWAIT,
    RSEND,
    ACK,
    ERR
  } state_t;

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_READ    = 8'h02;
  localparam logic [7:0] RSP_ACK     = 8'hA5;
  localparam logic [7:0] ERR_CMD     = 8'hE1;
  localparam logic [7:0] ERR_TIMEOUT = 8'hE2;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - host byte link plus imem port B, as seen by the loader
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);

  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_ready;
  logic                  en_b;
  logic                  we_b;
  logic [3:0]            wstrb_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [31:0]           din_b;
  logic [31:0]           dout_b;

  modport slave (
    input  rx_valid, rx_data, tx_ready, dout_b,
    output rx_ready, tx_valid, tx_data, en_b, we_b, wstrb_b, addr_b, din_b
  );

  modport master (
    output rx_valid, rx_data, tx_ready, dout_b,
    input  rx_ready, tx_valid, tx_data, en_b, we_b, wstrb_b, addr_b, din_b
  );

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader/reader owning imem port B, holds the core off per packet
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus,
  output logic         core_hold,
  output logic         busy
);

  localparam int             TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);

  state_t                state, state_nxt;
  logic [1:0]            byte_idx;
  logic [7:0]            cmd;
  logic [7:0]            addr_lo;
  logic [7:0]            cnt_lo;
  logic [7:0]            err_code;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           remaining;
  logic [31:0]           wword;
  logic [31:0]           rword;
  logic [TW-1:0]         idle_cnt;

  logic                  rx_ready_c;
  logic                  tx_valid_c;
  logic [7:0]            tx_data_c;
  logic                  en_c;
  logic                  we_c;
  logic [3:0]            wstrb_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [31:0]           din_c;
  logic                  rx_fire;
  logic                  tx_fire;
  logic                  timeout_hit;
  logic                  rx_phase;

  // rx_ready is gated by rst_n so every output reads 0 while reset is held
  assign rx_phase    = (state == IDLE) || (state == HDR) || (state == WDATA);
  assign rx_ready_c  = rst_n && rx_phase;
  assign tx_valid_c  = (state == RSEND) || (state == ACK) || (state == ERR);
  assign rx_fire     = bus.rx_valid && rx_ready_c;
  assign tx_fire     = tx_valid_c && bus.tx_ready;
  assign timeout_hit = TO_EN && ((state == HDR) || (state == WDATA)) && !rx_fire
                       && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_data_c = 8'h00;
    en_c      = 1'b0;
    we_c      = 1'b0;
    wstrb_c   = 4'h0;
    addr_c    = '0;
    din_c     = 32'h0;
    case (state)
      IDLE: begin
        if (rx_fire) state_nxt = is_cmd(bus.rx_data) ? HDR : ERR;
      end
      HDR: begin
        if (rx_fire && byte_idx == 2'd3) begin
          if ({bus.rx_data, cnt_lo} == 16'd0) state_nxt = ACK;
          else if (cmd == CMD_WRITE)          state_nxt = WDATA;
          else                                state_nxt = RREQ;
        end else if (timeout_hit) begin
          state_nxt = ERR;
        end
      end
      WDATA: begin
        if (rx_fire && byte_idx == 2'd3) state_nxt = WWRITE;
        else if (timeout_hit)            state_nxt = ERR;
      end
      WWRITE: begin
        en_c      = 1'b1;
        we_c      = 1'b1;
        wstrb_c   = 4'hF;
        addr_c    = addr;
        din_c     = wword;
        state_nxt = (remaining == 16'd1) ? ACK : WDATA;
      end
      RREQ: begin
        en_c      = 1'b1;
        addr_c    = addr;
        state_nxt = RWAIT;
      end
      RWAIT: state_nxt = RSEND;
      RSEND: begin
        tx_data_c = rword[7:0];
        if (tx_fire && byte_idx == 2'd3) state_nxt = (remaining == 16'd1) ? ACK : RREQ;
      end
      ACK: begin
        tx_data_c = RSP_ACK;
        if (tx_fire) state_nxt = IDLE;
      end
      ERR: begin
        tx_data_c = err_code;
        if (tx_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx  <= 2'd0;
      cmd       <= 8'h00;
      addr_lo   <= 8'h00;
      cnt_lo    <= 8'h00;
      err_code  <= 8'h00;
      addr      <= '0;
      remaining <= 16'd0;
      wword     <= 32'h0;
      rword     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_fire) begin
            cmd      <= bus.rx_data;
            byte_idx <= 2'd0;
            err_code <= ERR_CMD;
          end
        end
        HDR: begin
          if (rx_fire) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    addr_lo   <= bus.rx_data;
              2'd1:    addr      <= ADDR_WIDTH'({bus.rx_data, addr_lo});
              2'd2:    cnt_lo    <= bus.rx_data;
              default: remaining <= {bus.rx_data, cnt_lo};
            endcase
          end else if (timeout_hit) begin
            err_code <= ERR_TIMEOUT;
          end
        end
        WDATA: begin
          // little-endian assembly: the first byte ends up in bits [7:0]
          if (rx_fire) begin
            wword    <= {bus.rx_data, wword[31:8]};
            byte_idx <= byte_idx + 2'd1;
          end else if (timeout_hit) begin
            err_code <= ERR_TIMEOUT;
          end
        end
        WWRITE: begin
          addr      <= addr + ADDR_WIDTH'(1);
          remaining <= remaining - 16'd1;
        end
        RWAIT: begin
          rword    <= bus.dout_b;
          byte_idx <= 2'd0;
        end
        RSEND: begin
          if (tx_fire) begin
            rword    <= {8'h00, rword[31:8]};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              addr      <= addr + ADDR_WIDTH'(1);
              remaining <= remaining - 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // idle counter only runs while waiting on host bytes inside a packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!((state == HDR) || (state == WDATA)) || rx_fire) begin
      idle_cnt <= '0;
    end else if (TO_EN) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign bus.rx_ready = rx_ready_c;
  assign bus.tx_valid = tx_valid_c;
  assign bus.tx_data  = tx_data_c;
  assign bus.en_b     = en_c;
  assign bus.we_b     = we_c;
  assign bus.wstrb_b  = wstrb_c;
  assign bus.addr_b   = addr_c;
  assign bus.din_b    = din_c;
  assign busy         = (state != IDLE);
  assign core_hold    = (state != IDLE);

endmodule
